usb_token_crc_seq: RTL and testbench

Sequencer and arbiter that shares one `usb_crc5` engine between the USB token transmitter (CRC generation) and the token receiver (CRC check). It sits between the packet layers and the engine instance. It owns the engine's seed (`crc_rst`), enable and data inputs. It returns per-request results, plus a saturating receive-error count.

---
 rtl/usb_crc_pkg.sv | 19 +
 rtl/usb_crc_rr_arb.sv | 35 +++
 rtl/usb_token_crc_seq.sv | 154 +++++++++++++++
 tb/tb_usb_token_crc_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared widths and types for the USB token CRC5 sequencer and its arbiter.
package usb_crc_pkg;

  localparam int USB_TOKEN_FIELD_W = 11;
  localparam int USB_CRC5_W        = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    CALC = 2'd2,
    RESP = 2'd3
  } seq_state_e;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_id_e;

endpackage

// File: rtl/usb_crc_rr_arb.sv
// Two-input round-robin arbiter: one-hot grant, pointer advances past the winner on accept.
module usb_crc_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // ptr_q == 0 favours requester 0 (TX) when both request
  logic ptr_q;

  // Grant decode: a lone requester always wins, contention follows the pointer
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer update: after serving requester 0, favour requester 1, and vice versa
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept_i && (|gnt_o)) begin
      ptr_q <= gnt_o[0];
    end else begin
      ptr_q <= ptr_q;
    end
  end

endmodule

// File: rtl/usb_token_crc_seq.sv
// Shares one usb_crc5 engine between token TX (CRC generate) and token RX (CRC check).
// Build option: define USB_TOKEN_CRC_RX_CHECK_EN to enable the RX check path.
module usb_token_crc_seq
  import usb_crc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_req,
  input  logic [USB_TOKEN_FIELD_W-1:0] tx_data,
  output logic                         tx_gnt,
  output logic                         tx_done,
  output logic [USB_CRC5_W-1:0]        tx_crc,
  input  logic                         rx_req,
  input  logic [USB_TOKEN_FIELD_W-1:0] rx_data,
  input  logic [USB_CRC5_W-1:0]        rx_crc_in,
  output logic                         rx_gnt,
  output logic                         rx_done,
  output logic                         rx_crc_ok,
  output logic [ERR_CNT_W-1:0]         rx_err_cnt,
  output logic                         busy,
  output logic                         crc_rst,
  output logic                         crc_en,
  output logic [USB_TOKEN_FIELD_W-1:0] crc_data,
  input  logic [USB_CRC5_W-1:0]        crc_out
);

  seq_state_e                   state_q;
  req_id_e                      winner_q;
  logic [USB_TOKEN_FIELD_W-1:0] data_q;
  logic [USB_CRC5_W-1:0]        crc_exp_q;
  logic [USB_CRC5_W-1:0]        tx_crc_q;
  logic [1:0]                   gnt_q;
  logic                         crc_rst_q;
  logic                         crc_en_q;
  logic                         busy_q;
  logic                         tx_done_q;
  logic                         rx_done_q;
  logic                         rx_crc_ok_q;
  logic [ERR_CNT_W-1:0]         rx_err_cnt_q;

  logic       rx_req_s;
  logic [1:0] req_vec_s;
  logic [1:0] arb_gnt_s;
  logic       accept_s;
  logic       crc_match_s;

`ifdef USB_TOKEN_CRC_RX_CHECK_EN
  assign rx_req_s   = rx_req;
  assign rx_gnt     = gnt_q[1];
  assign rx_done    = rx_done_q;
  assign rx_crc_ok  = rx_crc_ok_q;
  assign rx_err_cnt = rx_err_cnt_q;
`else
  // RX path compiled out: requests never reach the arbiter, outputs are constant
  logic unused_rx_s;
  assign rx_req_s    = 1'b0;
  assign rx_gnt      = 1'b0;
  assign rx_done     = 1'b0;
  assign rx_crc_ok   = 1'b0;
  assign rx_err_cnt  = {ERR_CNT_W{1'b0}};
  assign unused_rx_s = ^{rx_req, gnt_q[1], rx_done_q, rx_crc_ok_q, rx_err_cnt_q};
`endif

  assign req_vec_s   = {rx_req_s, tx_req};
  assign accept_s    = (state_q == IDLE) && (|req_vec_s);
  assign crc_match_s = (crc_out == crc_exp_q);

  usb_crc_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_vec_s),
    .accept_i (accept_s),
    .gnt_o    (arb_gnt_s)
  );

  // Sequencer FSM with all engine-side and requester-side outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= REQ_TX;
      data_q       <= {USB_TOKEN_FIELD_W{1'b0}};
      crc_exp_q    <= {USB_CRC5_W{1'b0}};
      tx_crc_q     <= {USB_CRC5_W{1'b0}};
      gnt_q        <= 2'b00;
      crc_rst_q    <= 1'b1;
      crc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_crc_ok_q  <= 1'b0;
      rx_err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      gnt_q     <= 2'b00;
      crc_rst_q <= 1'b0;
      crc_en_q  <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q   <= SEED;
            busy_q    <= 1'b1;
            crc_rst_q <= 1'b1;
            gnt_q     <= arb_gnt_s;
            if (arb_gnt_s[1]) begin
              winner_q  <= REQ_RX;
              data_q    <= rx_data;
              crc_exp_q <= rx_crc_in;
            end else begin
              winner_q  <= REQ_TX;
              data_q    <= tx_data;
            end
          end
        end
        SEED: begin
          state_q  <= CALC;
          crc_en_q <= 1'b1;
        end
        CALC: begin
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (winner_q == REQ_RX) begin
            rx_done_q   <= 1'b1;
            rx_crc_ok_q <= crc_match_s;
            if (!crc_match_s && (rx_err_cnt_q != {ERR_CNT_W{1'b1}})) begin
              rx_err_cnt_q <= rx_err_cnt_q + ERR_CNT_W'(1'b1);
            end
          end else begin
            tx_done_q <= 1'b1;
            tx_crc_q  <= crc_out;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_gnt   = gnt_q[0];
  assign tx_done  = tx_done_q;
  assign tx_crc   = tx_crc_q;
  assign busy     = busy_q;
  assign crc_rst  = crc_rst_q;
  assign crc_en   = crc_en_q;
  assign crc_data = data_q;

endmodule

// File: tb/tb_usb_token_crc_seq.sv
// Directed bench for usb_token_crc_seq with a transaction-level reference model.
// RX-specific scenarios run only when USB_TOKEN_CRC_RX_CHECK_EN is defined.
module tb_usb_token_crc_seq;

  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef USB_TOKEN_CRC_RX_CHECK_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              tx_req    = 1'b0;
  logic [10:0]       tx_data   = 11'h000;
  logic              rx_req    = 1'b0;
  logic [10:0]       rx_data   = 11'h000;
  logic [4:0]        rx_crc_in = 5'h00;
  logic [4:0]        crc_out;
  logic [4:0]        stub_val  = 5'h00;
  logic              tx_gnt, tx_done, rx_gnt, rx_done, rx_crc_ok, busy, crc_rst, crc_en;
  logic [4:0]        tx_crc;
  logic [ERR_W-1:0]  rx_err_cnt;
  logic [10:0]       crc_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_token_crc_seq #(.ERR_CNT_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_gnt     (tx_gnt),
    .tx_done    (tx_done),
    .tx_crc     (tx_crc),
    .rx_req     (rx_req),
    .rx_data    (rx_data),
    .rx_crc_in  (rx_crc_in),
    .rx_gnt     (rx_gnt),
    .rx_done    (rx_done),
    .rx_crc_ok  (rx_crc_ok),
    .rx_err_cnt (rx_err_cnt),
    .busy       (busy),
    .crc_rst    (crc_rst),
    .crc_en     (crc_en),
    .crc_data   (crc_data),
    .crc_out    (crc_out)
  );

  // Engine stub: valid result only in the cycle after crc_en, garbage otherwise
  always @(posedge clk) crc_out <= crc_en ? stub_val : ~stub_val;

  int cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request occupies offsets 0..3 after the cycle it is seen
  bit         m_valid = 0, m_act = 0, m_win = 0, m_ptr_rx = 0, m_rst_prev = 0;
  bit         m_txd = 0, m_rxd = 0, m_rx_ok = 0;
  int         m_t0 = 0, m_err = 0;
  logic [10:0] m_data = 11'h000;
  logic [4:0]  m_exp = 5'h00, m_tx_crc = 5'h00;

  always @(negedge clk) begin : model
    int off;
    bit rxr;
    off = m_act ? (cyc - m_t0) : -1;
    if (m_valid) begin
      chk("tx_gnt",     tx_gnt,     (off == 1) && !m_win);
      chk("rx_gnt",     rx_gnt,     (off == 1) && m_win);
      chk("crc_rst",    crc_rst,    m_rst_prev || (off == 1));
      chk("crc_en",     crc_en,     off == 2);
      chk("busy",       busy,       (off >= 1) && (off <= 3));
      chk("crc_data",   crc_data,   m_data);
      chk("tx_done",    tx_done,    m_txd);
      chk("rx_done",    rx_done,    m_rxd);
      chk("tx_crc",     tx_crc,     m_tx_crc);
      chk("rx_crc_ok",  rx_crc_ok,  m_rx_ok);
      chk("rx_err_cnt", rx_err_cnt, m_err);
    end
    m_txd = 0;
    m_rxd = 0;
    if (rst) begin
      m_valid = 1; m_act = 0; m_ptr_rx = 0; m_rst_prev = 1;
      m_data = 11'h000; m_exp = 5'h00; m_tx_crc = 5'h00; m_rx_ok = 0; m_err = 0;
    end else begin
      m_rst_prev = 0;
      if (off == 3) begin
        m_act = 0;
        if (m_win) begin
          m_rxd   = 1;
          m_rx_ok = (stub_val == m_exp);
          if ((stub_val != m_exp) && (m_err < ERR_MAX)) m_err++;
        end else begin
          m_txd    = 1;
          m_tx_crc = stub_val;
        end
      end else if (!m_act) begin
        rxr = RX_EN && rx_req;
        if (tx_req || rxr) begin
          m_win    = (tx_req && rxr) ? m_ptr_rx : rxr;
          m_ptr_rx = !m_win;
          m_act    = 1;
          m_t0     = cyc;
          m_data   = m_win ? rx_data : tx_data;
          if (m_win) m_exp = rx_crc_in;
        end
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // One single-cycle request; returns inside cycle 4 (the done cycle)
  task automatic xact(bit is_rx, logic [10:0] d, logic [4:0] c, logic [4:0] sv);
    next_cycle();
    stub_val = sv;
    if (is_rx) begin
      rx_req = 1'b1; rx_data = d; rx_crc_in = c;
    end else begin
      tx_req = 1'b1; tx_data = d;
    end
    next_cycle();
    tx_req = 1'b0;
    rx_req = 1'b0;
    idle(3);
  endtask

  initial begin
    idle(3);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_crc_rst", crc_rst, 1'b1);
    next_cycle();
    rst = 1'b0;
    idle(2);

    // Single TX
    next_cycle();
    tx_req = 1'b1; tx_data = 11'h3A5; stub_val = 5'h1A;
    next_cycle();
    tx_req = 1'b0;
    @(negedge clk);
    chk("t1_gnt", tx_gnt, 1'b1);
    chk("t1_seed", crc_rst, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t1_en", crc_en, 1'b1);
    chk("t1_data", crc_data, 11'h3A5);
    idle(2);
    @(negedge clk);
    chk("t1_done", tx_done, 1'b1);
    chk("t1_crc", tx_crc, 5'h1A);
    idle(2);

`ifdef USB_TOKEN_CRC_RX_CHECK_EN
    // RX match
    xact(1'b1, 11'h155, 5'h0C, 5'h0C);
    @(negedge clk);
    chk("t2_done", rx_done, 1'b1);
    chk("t2_ok", rx_crc_ok, 1'b1);
    chk("t2_err", rx_err_cnt, 2'd0);

    // RX mismatch, then saturation of the 2-bit counter
    xact(1'b1, 11'h2AA, 5'h0D, 5'h0C);
    @(negedge clk);
    chk("t3_ok", rx_crc_ok, 1'b0);
    chk("t3_err1", rx_err_cnt, 2'd1);
    for (int i = 0; i < 4; i++) xact(1'b1, 11'h2AA, 5'h0D, 5'h0C);
    @(negedge clk);
    chk("t3_err_sat", rx_err_cnt, 2'd3);
    idle(2);

    // Contention: both held, grants alternate every 4 cycles
    next_cycle();
    tx_req = 1'b1; rx_req = 1'b1; tx_data = 11'h7FF; rx_data = 11'h001;
    rx_crc_in = 5'h0C; stub_val = 5'h0C;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      chk("t4_busy", busy, (k % 4) != 0);
      chk("t4_tx_gnt", tx_gnt, (k == 1) || (k == 9));
      chk("t4_rx_gnt", rx_gnt, k == 5);
    end
    next_cycle();
    tx_req = 1'b0; rx_req = 1'b0;
    idle(2);
`endif

    // Reset in CALC aborts the transaction
    next_cycle();
    tx_req = 1'b1; tx_data = 11'h0F0; stub_val = 5'h1A;
    next_cycle();
    tx_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_calc_en", crc_en, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_no_done", tx_done, 1'b0);
    chk("t5_seed", crc_rst, 1'b1);
    next_cycle();
    tx_req = 1'b1; tx_data = 11'h2AB; stub_val = 5'h15;
    next_cycle();
    tx_req = 1'b0;
    idle(3);
    @(negedge clk);
    chk("t5_done", tx_done, 1'b1);
    chk("t5_crc", tx_crc, 5'h15);
    idle(2);

`ifndef USB_TOKEN_CRC_RX_CHECK_EN
    // RX path compiled out: a held rx_req must be ignored
    next_cycle();
    rx_req = 1'b1; rx_data = 11'h123; rx_crc_in = 5'h0D;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t6_gnt", rx_gnt, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", rx_done, 1'b0);
      chk("t6_ok", rx_crc_ok, 1'b0);
      chk("t6_err", rx_err_cnt, 2'd0);
    end
    next_cycle();
    rx_req = 1'b0;
    idle(2);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
